serial_subtractor: RTL and testbench

//  Bit-serial subtractor: loads two WIDTH-bit operands in parallel, computes A - B
//  LSB-first, one bit per clock, through a single 1-bit full adder. B is inverted
//  and carry seeded to 1 (two's complement). Result is shifted into a parallel

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor_full_adder_1bit.sv | 13 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor, plus the FSM state for observation.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);

   // start is sampled only while idle (busy=0); done is a one-cycle pulse
   // marking diff/borrow valid, and they hold until the next accepted start.
   logic             start;
   logic [WIDTH-1:0] adata;
   logic [WIDTH-1:0] bdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   state_t           state;

   modport master (
      output start, adata, bdata,
      input  busy, done, diff, borrow, state
   );

   modport slave (
      input  start, adata, bdata,
      output busy, done, diff, borrow, state
   );

endinterface

// File: rtl/serial_subtractor_full_adder_1bit.sv
// One-bit full adder cell shared with the serial adder datapath.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B: LSB-first through one full adder with B inverted and carry seeded to 1.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;

   assign last_bit = (cnt == LAST);

   full_adder_1bit u_fa (
      .a  (a_reg[0]),
      .b  (~b_reg[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= SHIFT;
                  busy_r <= 1'b1;
               end
            end
            SHIFT: begin
               if (last_bit) begin
                  state  <= DONE;
                  done_r <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
         endcase
      end
   end

   // Carry out of the final bit is the inverse of the unsigned borrow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
         carry    <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_reg    <= bus.adata;
                  b_reg    <= bus.bdata;
                  diff_r   <= '0;
                  borrow_r <= 1'b0;
                  carry    <= 1'b1;
                  cnt      <= '0;
               end
            end
            SHIFT: begin
               a_reg  <= a_reg >> 1;
               b_reg  <= b_reg >> 1;
               diff_r <= {fa_s, diff_r[WIDTH-1:1]};
               carry  <= fa_co;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  borrow_r <= ~fa_co;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.diff   = diff_r;
   assign bus.borrow = borrow_r;
   assign bus.state  = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of the 8-bit serial subtractor.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   cyc;
   logic prev_done;
   logic [W:0] exp_q[$];

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // done must be a single-cycle pulse and always coincide with busy
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         n_cmp++;
         if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_with_done: busy=%b required 1", bus.busy);
         end
         n_cmp++;
         if (prev_done === 1'b1) begin
            n_err++;
            $display("FAIL done_width: done high two cycles running");
         end
      end
      prev_done = bus.done;
   end

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
   endtask

   // Launches one operation; returns edges from accept to done (inclusive) and a timeout flag.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic tmo);
      wait_idle();
      bus.start = 1'b1;
      bus.adata = a;
      bus.bdata = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.adata = $urandom_range(0, 255);
      bus.bdata = $urandom_range(0, 255);
      lat = 1;
      while (!bus.done && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      tmo = !bus.done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'd0 ||
          bus.borrow !== 1'b0 || bus.state !== IDLE) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b diff=%0d borrow=%b required 0 0 0 0",
                  bus.busy, bus.done, bus.diff, bus.borrow);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] va[4];
      logic [W-1:0] vb[4];
      logic [W-1:0] vd[4];
      logic         vbr[4];
      int           lat;
      logic         tmo;
      va = '{8'd100, 8'd37,  8'd0,   8'd255};
      vb = '{8'd37,  8'd100, 8'd1,   8'd255};
      vd = '{8'd63,  8'd193, 8'd255, 8'd0};
      vbr = '{1'b0,  1'b1,   1'b1,   1'b0};
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], lat, tmo);
         n_cmp++;
         if (tmo || lat != W + 1) begin
            n_err++;
            $display("FAIL latency[%0d]: edges=%0d timeout=%b required %0d", i, lat, tmo, W + 1);
         end
         n_cmp++;
         if (bus.diff !== vd[i] || bus.borrow !== vbr[i]) begin
            n_err++;
            $display("FAIL directed[%0d]: diff=%0d borrow=%b required %0d %b",
                     i, bus.diff, bus.borrow, vd[i], vbr[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      wait_idle();
      bus.start = 1'b1;
      bus.adata = 8'd100;
      bus.bdata = 8'd37;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.adata = 8'd5;
      bus.bdata = 8'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_cmp++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.diff !== 8'd63 || bus.borrow !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_mid_shift: done=%b busy=%b diff=%0d borrow=%b required 1 1 63 0",
                  bus.done, bus.busy, bus.diff, bus.borrow);
      end
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (bus.busy !== 1'b0 || bus.diff !== 8'd63 || bus.borrow !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_in_done: busy=%b diff=%0d borrow=%b required 0 63 0",
                     bus.busy, bus.diff, bus.borrow);
         end
      end
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic tmo;
      wait_idle();
      bus.start = 1'b1;
      bus.adata = 8'd100;
      bus.bdata = 8'd37;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.diff === 8'd0) begin
         n_err++;
         $display("FAIL pre_reset_busy: busy=%b diff=%0d required busy 1 and partial diff",
                  bus.busy, bus.diff);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'd0 || bus.borrow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_abort: busy=%b done=%b diff=%0d borrow=%b required 0 0 0 0",
                  bus.busy, bus.done, bus.diff, bus.borrow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'd200, 8'd55, lat, tmo);
      n_cmp++;
      if (tmo || bus.diff !== 8'd145 || bus.borrow !== 1'b0) begin
         n_err++;
         $display("FAIL after_reset: diff=%0d borrow=%b timeout=%b required 145 0",
                  bus.diff, bus.borrow, tmo);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   exp;
      int           lat;
      logic         tmo;
      int           last_done;
      last_done = -1;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         exp_q.push_back({(a < b), 8'(a - b)});
         do_op(a, b, lat, tmo);
         exp = exp_q.pop_front();
         n_cmp++;
         if (tmo || {bus.borrow, bus.diff} !== exp) begin
            n_err++;
            $display("FAIL random[%0d] a=%0d b=%0d: diff=%0d borrow=%b required %0d %b",
                     i, a, b, bus.diff, bus.borrow, exp[W-1:0], exp[W]);
         end
         if (last_done >= 0) begin
            n_cmp++;
            if (cyc - last_done != W + 2) begin
               n_err++;
               $display("FAIL throughput[%0d]: period=%0d required %0d", i, cyc - last_done, W + 2);
            end
         end
         last_done = cyc;
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      cyc       = 0;
      prev_done = 1'b0;
      bus.start = 1'b0;
      bus.adata = '0;
      bus.bdata = '0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
